// File: rtl/cnn_loader_pkg.sv
// rtl/cnn_loader_pkg.sv - shared state encoding and error codes for the CNN pixel frame loader
// Contents: loader_state_t (IDLE, LOAD, READY, STREAM) and the 32-bit error code constants.
package cnn_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        READY  = 2'd2,
        STREAM = 2'd3
    } loader_state_t;

    localparam logic [31:0] ERR_NONE             = 32'd0;
    localparam logic [31:0] ERR_OVERFLOW         = 32'd1;
    localparam logic [31:0] ERR_SHORT_FRAME      = 32'd2;
    localparam logic [31:0] ERR_START_WHILE_BUSY = 32'd3;

endpackage

// File: rtl/cnn_frame_ram.sv
// rtl/cnn_frame_ram.sv - simple dual-port frame buffer, one write port, one synchronous read port
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read port; rd_data valid one
// cycle after rd_en and held while rd_en is low (the loader relies on this hold).
module cnn_frame_ram #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cnn_pixel_frame_loader.sv
// rtl/cnn_pixel_frame_loader.sv - buffers one pixel frame and streams it to the CNN core
// Inputs: clk, rst, frame_start, pixel_valid, pixel_data, frame_complete, cnn_reset, err_clr,
// cnn_busy, out_ready. Outputs: cnn_start pulse, out_valid/out_data/out_last stream,
// loader_busy, frame_ready, pixel_count, sticky error_code.
module cnn_pixel_frame_loader
    import cnn_loader_pkg::*;
#(
    parameter int FRAME_PIXELS = 1024,
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = $clog2(FRAME_PIXELS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pixel_valid,
    input  logic [DATA_W-1:0] pixel_data,
    input  logic              frame_complete,
    input  logic              cnn_reset,
    input  logic              err_clr,
    input  logic              cnn_busy,
    output logic              cnn_start,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              loader_busy,
    output logic              frame_ready,
    output logic [ADDR_W:0]   pixel_count,
    output logic [31:0]       error_code
);

    localparam logic [ADDR_W:0] FULL      = (ADDR_W + 1)'(FRAME_PIXELS);
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(FRAME_PIXELS - 1);

    loader_state_t     state_q, state_d;
    logic [ADDR_W:0]   count_d, count_after;
    logic [ADDR_W:0]   rd_ptr;
    logic              wr_en, rd_en;
    logic              err_set;
    logic [31:0]       err_val;
    logic              adv;
    // The RAM output acts as a pipeline stage in front of the output register;
    // q_valid/q_last describe the word currently sitting on q_data.
    logic              q_valid, q_last;
    logic [DATA_W-1:0] q_data;

    cnn_frame_ram #(
        .DEPTH  (FRAME_PIXELS),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (pixel_count[ADDR_W-1:0]),
        .wr_data (pixel_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (q_data)
    );

    assign loader_busy = (state_q != IDLE);
    assign frame_ready = (state_q == READY);
    // Output register may take a new word when empty or being accepted.
    assign adv = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = pixel_count;
        count_after = pixel_count;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        err_set     = 1'b0;
        err_val     = ERR_NONE;
        cnn_start   = 1'b0;
        if (cnn_reset) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        state_d = LOAD;
                        count_d = '0;
                    end
                end
                LOAD: begin
                    // A restart dominates any pixel or completion in the same cycle.
                    if (frame_start) begin
                        count_d = '0;
                    end else begin
                        if (pixel_valid) begin
                            if (pixel_count == FULL) begin
                                err_set = 1'b1;
                                err_val = ERR_OVERFLOW;
                            end else begin
                                wr_en       = 1'b1;
                                count_after = pixel_count + (ADDR_W + 1)'(1);
                            end
                        end
                        count_d = count_after;
                        if (frame_complete) begin
                            if (count_after == FULL) begin
                                state_d = READY;
                            end else begin
                                state_d = IDLE;
                                err_set = 1'b1;
                                err_val = ERR_SHORT_FRAME;
                            end
                        end
                    end
                end
                READY: begin
                    if (frame_start) begin
                        err_set = 1'b1;
                        err_val = ERR_START_WHILE_BUSY;
                    end
                    // The first read is issued with cnn_start so data is out two cycles later.
                    if (!cnn_busy) begin
                        cnn_start = 1'b1;
                        rd_en     = 1'b1;
                        state_d   = STREAM;
                    end
                end
                STREAM: begin
                    if (frame_start) begin
                        err_set = 1'b1;
                        err_val = ERR_START_WHILE_BUSY;
                    end
                    rd_en = (adv || !q_valid) && (rd_ptr < FULL);
                    if (out_valid && out_ready && out_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_count <= '0;
            error_code  <= ERR_NONE;
            rd_ptr      <= '0;
            q_valid     <= 1'b0;
            q_last      <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
        end else begin
            pixel_count <= count_d;
            if (err_set) begin
                error_code <= err_val;
            end else if (err_clr) begin
                error_code <= ERR_NONE;
            end
            if (cnn_reset) begin
                rd_ptr    <= '0;
                q_valid   <= 1'b0;
                q_last    <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                if (rd_en) begin
                    rd_ptr <= rd_ptr + (ADDR_W + 1)'(1);
                    q_last <= (rd_ptr == LAST_ADDR);
                end else if (state_q == IDLE) begin
                    rd_ptr <= '0;
                end
                if (rd_en) begin
                    q_valid <= 1'b1;
                end else if (adv) begin
                    q_valid <= 1'b0;
                end
                if (adv) begin
                    out_valid <= q_valid;
                    out_data  <= q_data;
                    out_last  <= q_valid && q_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_cnn_pixel_frame_loader.sv
// tb/tb_cnn_pixel_frame_loader.sv - directed self-checking bench for cnn_pixel_frame_loader
module tb_cnn_pixel_frame_loader;

    localparam int FP = 16;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start, pixel_valid, frame_complete;
    logic [DW-1:0] pixel_data;
    logic          cnn_reset, err_clr, cnn_busy, out_ready;
    logic          cnn_start, out_valid, out_last, loader_busy, frame_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   pixel_count;
    logic [31:0]   error_code;

    int n_err    = 0;
    int n_checks = 0;

    logic [DW-1:0] got_data[$];
    logic          got_last[$];
    int starts, start_cyc, first_valid, first_acc, last_acc;

    always #5 clk = ~clk;

    cnn_pixel_frame_loader #(.FRAME_PIXELS(FP), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pixel_valid(pixel_valid),
        .pixel_data(pixel_data), .frame_complete(frame_complete), .cnn_reset(cnn_reset),
        .err_clr(err_clr), .cnn_busy(cnn_busy), .cnn_start(cnn_start), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .loader_busy(loader_busy), .frame_ready(frame_ready), .pixel_count(pixel_count),
        .error_code(error_code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int n);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            pixel_valid = 1'b1;
            pixel_data  = DW'(i);
            tick();
        end
        pixel_valid    = 1'b0;
        frame_complete = 1'b1;
        tick();
        frame_complete = 1'b0;
    endtask

    task automatic run_stream(input bit toggle, input int inj_cyc);
        bit            done, stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        done = 1'b0; stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        got_data.delete(); got_last.delete();
        starts = 0; start_cyc = -1; first_valid = -1; first_acc = -1; last_acc = -1;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            out_ready   = toggle ? (cyc % 2 == 0) : 1'b1;
            frame_start = (cyc == inj_cyc);
            @(negedge clk);
            if (cnn_start) begin
                starts++;
                if (start_cyc < 0) start_cyc = cyc;
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
            end
            stall     = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                if (out_last) done = 1'b1;
            end
            tick();
        end
        frame_start = 1'b0;
        out_ready   = 1'b1;
        check("stream_done", done, 1);
        @(negedge clk);
        check("post_last_valid", out_valid, 0);
        check("post_last_idle", loader_busy, 0);
    endtask

    task automatic check_stream();
        check("stream_len", got_data.size(), FP);
        for (int i = 0; i < FP; i++) begin
            check($sformatf("data%0d", i), (i < got_data.size()) ? 32'(got_data[i]) : 32'hFFFF, i);
            check($sformatf("last%0d", i), (i < got_last.size()) ? 32'(got_last[i]) : 32'hFFFF,
                  (i == FP - 1) ? 1 : 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int early, acc;
        bit aborted;
        rst = 1'b1; frame_start = 1'b0; pixel_valid = 1'b0; frame_complete = 1'b0;
        pixel_data = '0; cnn_reset = 1'b0; err_clr = 1'b0; cnn_busy = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Reset state
        check("rst_start", cnn_start, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", loader_busy, 0);
        check("rst_ready", frame_ready, 0);
        check("rst_count", pixel_count, 0);
        check("rst_err", error_code, 0);

        // Nominal frame
        send_frame(16);
        check("nom_frame_ready", frame_ready, 1);
        check("nom_count", pixel_count, 16);
        run_stream(1'b0, -1);
        check_stream();
        check("nom_starts", starts, 1);
        check("nom_start_to_valid", first_valid - start_cyc, 2);
        check("nom_no_bubbles", last_acc - first_acc, FP - 1);
        check("nom_err", error_code, 0);

        // Backpressure and busy stall
        cnn_busy = 1'b1;
        send_frame(16);
        early = 0;
        repeat (10) begin
            @(negedge clk);
            if (cnn_start) early++;
        end
        check("busy_hold_start", early, 0);
        check("busy_frame_ready", frame_ready, 1);
        tick();
        cnn_busy = 1'b0;
        run_stream(1'b1, -1);
        check_stream();
        check("bp_starts", starts, 1);
        check("bp_err", error_code, 0);

        // Short frame
        send_frame(10);
        check("short_err", error_code, 2);
        check("short_idle", loader_busy, 0);
        check("short_count", pixel_count, 10);
        early = 0;
        repeat (4) begin
            @(negedge clk);
            if (cnn_start) early++;
        end
        check("short_no_start", early, 0);
        check("short_count_hold", pixel_count, 10);
        tick();

        // Overflow
        send_frame(18);
        check("ovf_err", error_code, 1);
        check("ovf_count", pixel_count, 16);
        check("ovf_frame_ready", frame_ready, 1);
        run_stream(1'b0, -1);
        check_stream();

        // Start while busy, then err_clr
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_before_sw", error_code, 0);
        send_frame(16);
        run_stream(1'b0, 4);
        check_stream();
        check("sw_err", error_code, 3);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("sw_err_clr", error_code, 0);

        // Abort on the 5th accepted pixel; error_code must survive cnn_reset
        cnn_busy = 1'b1;
        send_frame(16);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("ready_start_err", error_code, 3);
        cnn_busy = 1'b0;
        acc = 0; aborted = 1'b0;
        for (int cyc = 0; cyc < 100 && !aborted; cyc++) begin
            out_ready = 1'b1;
            @(negedge clk);
            if (out_valid && out_ready) acc++;
            if (acc == 5) begin
                cnn_reset = 1'b1;
                aborted   = 1'b1;
            end
            tick();
        end
        cnn_reset = 1'b0;
        check("abort_reached", aborted, 1);
        @(negedge clk);
        check("abort_valid", out_valid, 0);
        check("abort_idle", loader_busy, 0);
        check("abort_count", pixel_count, 0);
        check("abort_err_kept", error_code, 3);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        send_frame(16);
        run_stream(1'b0, -1);
        check_stream();
        check("after_abort_starts", starts, 1);

        // Asynchronous reset mid-LOAD
        send_frame(5);
        check("pre_async_err", error_code, 2);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pixel_valid = 1'b1;
            pixel_data  = DW'(8'hA0 + i);
            tick();
        end
        pixel_valid = 1'b0;
        check("pre_async_busy", loader_busy, 1);
        check("pre_async_count", pixel_count, 5);
        #2 rst = 1'b1;
        #1;
        check("async_busy", loader_busy, 0);
        check("async_count", pixel_count, 0);
        check("async_err", error_code, 0);
        check("async_valid", out_valid, 0);
        check("async_start", cnn_start, 0);
        check("async_ready", frame_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cnn_pixel_frame_loader.md
Name: cnn_pixel_frame_loader

Overview:
- Sits directly downstream of the MicroBlaze-driven CNN control logic.
- Consumes its single-cycle pixel_valid/pixel_data pulses, framed by frame_start and frame_complete, and buffers one complete frame in on-chip RAM.
- Once the frame is complete and the CNN core is not busy, pulses the CNN start and streams the frame to the core over a valid/ready interface.
- Detects and reports malformed frames through a sticky error code and exposes status bits.

Parameters:
- FRAME_PIXELS, 1024, pixels per frame (32x32); must be >= 2.
- DATA_W, 8, pixel width in bits.
- ADDR_W, $clog2(FRAME_PIXELS), buffer address and pixel-count width (derived; do not override).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse; opens a new frame.
- pixel_valid  in  1  one-cycle pulse; pixel_data is valid this cycle.
- pixel_data  in  DATA_W  pixel value.
- frame_complete  in  1  one-cycle pulse; closes the frame.
- cnn_reset  in  1  synchronous abort to IDLE; buffer contents are don't-care afterwards.
- err_clr  in  1  clears error_code.
- cnn_busy  in  1  the CNN core is processing.
- cnn_start  out  1  one-cycle pulse issued before streaming begins.
- out_valid  out  1  streamed pixel valid.
- out_data  out  DATA_W  streamed pixel.
- out_last  out  1  marks pixel FRAME_PIXELS-1.
- out_ready  in  1  the CNN core accepts the current pixel.
- loader_busy  out  1  state is not IDLE.
- frame_ready  out  1  state is READY.
- pixel_count  out  ADDR_W+1  pixels written in the current frame.
- error_code  out  32  sticky error code.

Behaviour:
- Reset values:
  - All outputs are 0 and error_code = 0.
  - State is IDLE and write/read pointers are 0.
- FSM states and transitions:
  - IDLE: frame_start -> LOAD and clear pixel_count.
  - LOAD, pixel handling: each pixel_valid writes pixel_data at address pixel_count, then pixel_count increments.
    - A pixel_valid when pixel_count == FRAME_PIXELS is dropped and sets error 0x1 (OVERFLOW).
    - pixel_count saturates at FRAME_PIXELS.
  - LOAD, frame_complete:
    - If pixel_count == FRAME_PIXELS -> READY.
    - Otherwise set error 0x2 (SHORT_FRAME) and go to IDLE.
    - A pixel_valid in the same cycle as frame_complete is written first and counted before the comparison.
  - LOAD, frame_start: a frame_start in LOAD restarts the frame with pixel_count = 0. It is not an error.
  - READY: wait until cnn_busy == 0, then pulse cnn_start for exactly one cycle -> STREAM.
  - STREAM: out_valid rises 2 cycles after the cnn_start pulse (1 cycle synchronous RAM read plus the output register).
- Streaming handshake:
  - A transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, out_data and out_last hold stable.
  - The RAM is prefetched so a back-to-back ready stream sustains 1 pixel/clk with no bubbles.
  - The transfer with out_last = 1 returns to IDLE the next cycle, with out_valid = 0.
- Input events outside LOAD:
  - frame_start in READY or STREAM is ignored and sets error 0x3 (START_WHILE_BUSY).
  - pixel_valid and frame_complete outside LOAD are ignored and are not errors.
- error_code register:
  - Holds the most recent error code.
  - err_clr forces it to 0.
  - If err_clr and a new error occur in the same cycle, the new error wins.
- cnn_reset: has priority over all other inputs in every state.
  - Forces IDLE.
  - Deasserts out_valid in the same clock edge.
  - Clears pixel_count.
  - Does not clear error_code.
- Asynchronous rst mid-stream: all outputs drop to their reset values immediately, without waiting for a clock edge.
- Arithmetic: pixel_count is ADDR_W+1 bits wide so it can represent FRAME_PIXELS.

Decomposition:
- Shared package cnn_loader_pkg holds:
  - The state enum (IDLE, LOAD, READY, STREAM).
  - The error constants ERR_NONE = 0, ERR_OVERFLOW = 1, ERR_SHORT_FRAME = 2, ERR_START_WHILE_BUSY = 3.
- One sub-module: cnn_frame_ram.
  - Simple dual-port RAM, 1 write port and 1 read port.
  - Synchronous read with 1-cycle latency.
  - Depth FRAME_PIXELS, width DATA_W.
  - Inferred as BRAM.

Test Plan (all scenarios use FRAME_PIXELS = 16):
- Nominal frame: frame_start, then 16 pixels 0x00..0x0F, then frame_complete, with cnn_busy = 0 and out_ready held at 1.
  - cnn_start pulses once, then out_data = 0x00..0x0F on consecutive cycles.
  - out_last is asserted only with 0x0F; error_code = 0; the FSM returns to IDLE.
- Backpressure and busy stall: the same frame with out_ready toggled at 50% and cnn_busy = 1 for 10 cycles after frame_complete.
  - cnn_start is held off until cnn_busy falls.
  - Data holds stable during stalls and no pixel is lost or duplicated.
- Short frame: 10 pixels, then frame_complete.
  - error_code = 0x2, no cnn_start, state IDLE, pixel_count = 10 until the next frame_start.
- Overflow: 18 pixels, then frame_complete.
  - error_code = 0x1 and pixel_count saturates at 16.
  - The frame streams pixels 0..15; the extra 2 are dropped.
- Start while busy: frame_start during STREAM.
  - error_code = 0x3 and the stream completes unaffected.
  - err_clr then returns error_code to 0.
- Abort: cnn_reset asserted on the 5th accepted output pixel.
  - out_valid = 0 on the next cycle and the FSM goes to IDLE.
  - A subsequent nominal frame streams correctly.
  - Asynchronous rst mid-LOAD clears all outputs immediately.
